// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
package mult_pkg;

    localparam int MULT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    // Step counter must be able to represent WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: result = en ? -val : val (combinational).
module mult_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic [W-1:0] res_o
);

    assign res_o = en_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add signed/unsigned multiplier: WIDTH+1 cycle latency, start ignored while busy.
// Magnitudes are multiplied unsigned; the sign is applied once at the end.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic                 done_q, done_d;

    logic                 load_en, step_en, fin_en;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   z_fix;

    mult_abs #(.W(WIDTH)) u_abs_a (
        .val_i (a),
        .en_i  (is_signed & a[WIDTH-1]),
        .res_o (a_mag)
    );

    mult_abs #(.W(WIDTH)) u_abs_b (
        .val_i (b),
        .en_i  (is_signed & b[WIDTH-1]),
        .res_o (b_mag)
    );

    mult_abs #(.W(2*WIDTH)) u_sign_fix (
        .val_i (acc_q),
        .en_i  (neg_q),
        .res_o (z_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = SIGN;
            SIGN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        load_en = (state_q == IDLE) && start;
        step_en = (state_q == CALC);
        fin_en  = (state_q == SIGN);
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        z_d      = z_q;
        done_d   = fin_en;
        if (load_en) begin
            // Magnitude is zero-extended: |most-negative| needs the full unsigned range.
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
        if (step_en) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
        if (fin_en) begin
            z_d = z_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            z_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign z    = z_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomized checks of seq_mult (WIDTH=32) against an arithmetic product model.
module tb_seq_mult;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [2*W-1:0] z;

    int checks = 0;
    int errors = 0;

    seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .z         (z)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from the current cycle and returns in the done cycle.
    task automatic do_op(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit full, output logic [2*W-1:0] res);
        int n;
        int busy_hi;
        is_signed = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        step();
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
        n       = 0;
        busy_hi = 0;
        while (done !== 1'b1 && n < LAT + 8) begin
            if (busy === 1'b1) busy_hi++;
            step();
            n++;
        end
        res = z;
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_z"}, z, ref_prod(s, x, y));
        if (full) begin
            chk({tag, "_busy_cycles"}, 64'(busy_hi), 64'(LAT));
            chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        logic [2*W-1:0] r;
        int             ndone;
        int             first_lat;
        bit             saw6;

        step();
        step();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_z", z, 64'(0));
        reset = 1'b0;
        step();

        do_op("signed_mixed", 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1, r);
        chk("signed_mixed_lit", r, 64'hFFFF_FFFF_FFFF_FFEB);
        step();
        chk("done_one_cycle", 64'(done), 64'(0));

        do_op("min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, r);
        chk("min_sq_lit", r, 64'h4000_0000_0000_0000);
        do_op("umax_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r);
        chk("umax_sq_lit", r, 64'hFFFF_FFFE_0000_0001);
        do_op("min_x1", 1'b1, 32'h8000_0000, 32'd1, 1'b1, r);
        chk("min_x1_lit", r, 64'hFFFF_FFFF_8000_0000);

        // Second start five cycles in must be dropped.
        step();
        is_signed = 1'b0;
        a = 32'd9;
        b = 32'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        first_lat = 0;
        saw6 = 1'b0;
        for (int n = 1; n <= LAT + 8; n++) begin
            if (n == 5) begin
                a = 32'd2;
                b = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            if (done === 1'b1) begin
                ndone++;
                if (first_lat == 0) first_lat = n;
            end
            if (z === 64'd6) saw6 = 1'b1;
        end
        chk("ign_done_count", 64'(ndone), 64'(1));
        chk("ign_latency", 64'(first_lat), 64'(LAT));
        chk("ign_z", z, 64'd99);
        chk("ign_never6", 64'(saw6), 64'(0));

        // Reset mid-operation, with a nonzero z held from before.
        is_signed = 1'b0;
        a = 32'd100;
        b = 32'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 10; n++) step();
        reset = 1'b1;
        step();
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_done", 64'(done), 64'(0));
        chk("rst_mid_z", z, 64'(0));
        reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'(0));
        do_op("after_rst", 1'b0, 32'd3, 32'd4, 1'b1, r);
        chk("after_rst_lit", r, 64'd12);

        // Back-to-back: second start issued in the done cycle.
        step();
        do_op("b2b_first", 1'b0, 32'd5, 32'd6, 1'b1, r);
        chk("b2b_first_lit", r, 64'd30);
        do_op("b2b_second", 1'b0, 32'd0, 32'h1234, 1'b1, r);
        chk("b2b_second_lit", r, 64'd0);
        step();
        chk("b2b_done_once", 64'(done), 64'(0));

        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] x, y;
            logic         s;
            x = $urandom;
            y = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: x = 32'h8000_0000;
                1: y = 32'h0;
                2: x = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op("rand", s, x, y, 1'b0, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
